// File: rtl/poly_mult_sched.sv
// rtl/poly_mult_sched.sv - slot-table builder, dummy-pair inserter and host arbiter for poly_mult
//
// Purpose: buffers host-loaded real locations. On go it builds a slot table
// padded towards MAX_WEIGHT with identical random dummy pairs, which cancel
// under XOR accumulation. It then starts the multiplier, answers its location
// lookups, and hands result reads back to the host once the product is done.
//
// Ports:
//   clk, rst                                  clock, async active-high reset
//   loc_wr_en/loc_wr_addr/loc_wr_data         host real-location writes (IDLE only)
//   weight, go                                real-location count, start pulse
//   busy, done, err                           status (err is sticky until next accepted go)
//   rd_req, rd_addr, rd_data                  host result read (IDLE only)
//   pm_start, pm_weight                       multiplier start pulse and slot count
//   pm_loc_addr, pm_loc_in                    multiplier slot lookup (combinational)
//   pm_valid                                  multiplier completion pulse
//   pm_rd_dout, pm_addr_result, pm_dout       multiplier result-memory port
module poly_mult_sched #(
  parameter int          MAX_WEIGHT     = 75,
  parameter int          N              = 17669,
  parameter int          M              = 15,
  parameter int          LOG_MAX_WEIGHT = 7,
  parameter int          RES_AW         = 8,
  parameter int          W_BY_X         = 128,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      loc_wr_en,
  input  logic [LOG_MAX_WEIGHT-1:0] loc_wr_addr,
  input  logic [M-1:0]              loc_wr_data,
  input  logic [LOG_MAX_WEIGHT:0]   weight,
  input  logic                      go,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic                      rd_req,
  input  logic [RES_AW-1:0]         rd_addr,
  output logic [W_BY_X-1:0]         rd_data,
  output logic                      pm_start,
  output logic [LOG_MAX_WEIGHT:0]   pm_weight,
  input  logic [15:0]               pm_loc_addr,
  output logic [M-1:0]              pm_loc_in,
  input  logic                      pm_valid,
  output logic                      pm_rd_dout,
  output logic [RES_AW-1:0]         pm_addr_result,
  input  logic [W_BY_X-1:0]         pm_dout
);

  localparam int WW = LOG_MAX_WEIGHT + 1;

  typedef enum logic [2:0] {S_IDLE, S_BUILD, S_START, S_WAIT, S_DONE} state_t;

  state_t                    state_q;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [WW-1:0]             total_q, real_left_q, pairs_left_q, slot_q, pm_weight_q;
  logic [LOG_MAX_WEIGHT-1:0] ridx_q;
  logic                      second_q;   // next BUILD cycle writes the second half of a pair
  logic [M-1:0]              dval_q;
  logic                      busy_q, done_q, err_q, pm_start_q;

  logic [M-1:0] loc_ram  [MAX_WEIGHT];
  logic [M-1:0] slot_ram [MAX_WEIGHT];

  logic [WW-1:0] pairs_w, total_w;
  logic          weight_bad, take_dummy;
  logic [M-1:0]  d_raw, dummy_loc, slot_wdata;

  assign weight_bad = (weight == '0) || (weight > WW'(MAX_WEIGHT));
  assign pairs_w    = (WW'(MAX_WEIGHT) - weight) >> 1;
  assign total_w    = weight + (pairs_w << 1);

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // A 15-bit value is below 2N, so a single conditional subtract lands in [0, N-1].
  assign d_raw     = M'(lfsr_q[14:0]);
  assign dummy_loc = (d_raw >= M'(N)) ? d_raw - M'(N) : d_raw;

  always_comb begin
    take_dummy = 1'b0;
    if (real_left_q == '0)       take_dummy = 1'b1;
    else if (pairs_left_q == '0) take_dummy = 1'b0;
    else                         take_dummy = lfsr_q[0];

    slot_wdata = loc_ram[ridx_q];
    if (second_q)        slot_wdata = dval_q;
    else if (take_dummy) slot_wdata = dummy_loc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= SEED;
      total_q      <= '0;
      real_left_q  <= '0;
      pairs_left_q <= '0;
      slot_q       <= '0;
      ridx_q       <= '0;
      second_q     <= 1'b0;
      dval_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pm_start_q   <= 1'b0;
      pm_weight_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      pm_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            if (weight_bad) begin
              err_q <= 1'b1;
            end else begin
              err_q        <= 1'b0;
              busy_q       <= 1'b1;
              pairs_left_q <= pairs_w;
              total_q      <= total_w;
              real_left_q  <= weight;
              slot_q       <= '0;
              ridx_q       <= '0;
              second_q     <= 1'b0;
              state_q      <= S_BUILD;
            end
          end
        end
        S_BUILD: begin
          lfsr_q <= lfsr_d;
          slot_q <= slot_q + WW'(1);
          if (second_q) begin
            second_q <= 1'b0;
          end else if (take_dummy) begin
            second_q     <= 1'b1;
            dval_q       <= dummy_loc;
            pairs_left_q <= pairs_left_q - WW'(1);
          end else begin
            ridx_q      <= ridx_q + LOG_MAX_WEIGHT'(1);
            real_left_q <= real_left_q - WW'(1);
          end
          if (slot_q + WW'(1) == total_q) begin
            state_q     <= S_START;
            pm_start_q  <= 1'b1;
            pm_weight_q <= total_q;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (pm_valid) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Table storage carries no reset; its contents are only meaningful after a BUILD.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && loc_wr_en && loc_wr_addr < LOG_MAX_WEIGHT'(MAX_WEIGHT))
      loc_ram[loc_wr_addr] <= loc_wr_data;
    if (state_q == S_BUILD)
      slot_ram[slot_q[LOG_MAX_WEIGHT-1:0]] <= slot_wdata;
  end

  always_comb begin
    pm_loc_in = '0;
    if (pm_loc_addr < 16'(total_q))
      pm_loc_in = slot_ram[pm_loc_addr[LOG_MAX_WEIGHT-1:0]];
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign pm_start       = pm_start_q;
  assign pm_weight      = pm_weight_q;
  assign pm_rd_dout     = rd_req && (state_q == S_IDLE) && !busy_q;
  assign pm_addr_result = rd_addr;
  assign rd_data        = pm_dout;

endmodule
